// File: rtl/sram_port_arbiter_if.sv
// Purpose: bundles the three requester ports (IF, LS, DMA), the shared read
// data return and the SRAM array side of sram_port_arbiter into one interface.
// Ports: slave = arbiter view (requests/sram_rdata in; grants/rvalid/rdata/sram_* out),
//        master = environment view (core, DMA and SRAM model), directions mirrored.
// Optional ARB_PERF_CNT_EN adds the 32-bit perf_* counter outputs.
interface sram_port_arbiter_if #(
    parameter int SRAM_AW = 12
);
    // Instruction fetch (read only)
    logic               if_req;
    logic [31:0]        if_addr;
    logic               if_gnt;
    logic               if_rvalid;
    // Load/store
    logic               ls_req;
    logic               ls_we;
    logic [31:0]        ls_addr;
    logic [31:0]        ls_wdata;
    logic [3:0]         ls_be;
    logic               ls_gnt;
    logic               ls_rvalid;
    // DMA
    logic               dma_req;
    logic               dma_we;
    logic               dma_lock;
    logic [31:0]        dma_addr;
    logic [31:0]        dma_wdata;
    logic               dma_gnt;
    logic               dma_rvalid;
    // Shared read return
    logic [31:0]        rdata;
    // SRAM array side
    logic               sram_en;
    logic               sram_we;
    logic [3:0]         sram_be;
    logic [SRAM_AW-1:0] sram_addr;
    logic [31:0]        sram_wdata;
    logic [31:0]        sram_rdata;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]        perf_if_grants;
    logic [31:0]        perf_ls_grants;
    logic [31:0]        perf_dma_grants;
    logic [31:0]        perf_conflict;
`endif

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        input  sram_rdata,
        output if_gnt, if_rvalid, ls_gnt, ls_rvalid, dma_gnt, dma_rvalid,
        output sram_en, sram_we, sram_be, sram_addr, sram_wdata,
        output rdata
`ifdef ARB_PERF_CNT_EN
        , output perf_if_grants, perf_ls_grants, perf_dma_grants, perf_conflict
`endif
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata, ls_be,
        output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
        output sram_rdata,
        input  if_gnt, if_rvalid, ls_gnt, ls_rvalid, dma_gnt, dma_rvalid,
        input  sram_en, sram_we, sram_be, sram_addr, sram_wdata,
        input  rdata
`ifdef ARB_PERF_CNT_EN
        , input perf_if_grants, perf_ls_grants, perf_dma_grants, perf_conflict
`endif
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose: shares one single-port SRAM between core fetch (IF), core load/store (LS)
// and DMA. Fixed priority LS > IF > DMA, DMA aging to top priority after MAX_WAIT
// denied cycles, locked DMA bursts of up to MAX_BURST beats followed by a one-cycle
// yield. Latency: grant is combinational; read data/rvalid return one cycle later.
// Backpressure: a requester holds its request until its *_gnt; losers simply wait.
// Ports: clk_i, rst_i (synchronous, active-high), bus (sram_port_arbiter_if.slave).
// Optional: define ARB_PERF_CNT_EN to add grant/conflict performance counters.
module sram_port_arbiter #(
    parameter int SRAM_AW   = 12,
    parameter int MAX_WAIT  = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    sram_port_arbiter_if.slave  bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic [1:0] {ST_ARB, ST_LOCK, ST_YIELD} state_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_IF, TAG_LS, TAG_DMA} tag_e;

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q,  wait_d;
    logic [BW-1:0] beat_q,  beat_d;
    tag_e          tag_q,   tag_d;

    logic if_gnt, ls_gnt, dma_gnt;
    logic dma_aged;

    assign dma_aged = bus.dma_req && (wait_q == WAIT_MAX);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ARB;
            wait_q  <= '0;
            beat_q  <= '0;
            tag_q   <= TAG_NONE;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            beat_q  <= beat_d;
            tag_q   <= tag_d;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: grants. Suppressed while reset is asserted so nothing
    // reaches the SRAM during the reset cycle.
    // ------------------------------------------------------------------
    always_comb begin
        if_gnt  = 1'b0;
        ls_gnt  = 1'b0;
        dma_gnt = 1'b0;
        if (!rst_i) begin
            case (state_q)
                ST_LOCK: begin
                    dma_gnt = bus.dma_req;
                end
                ST_YIELD: begin
                    // Aging and lock are ignored here: DMA only gets leftovers.
                    if (bus.ls_req)       ls_gnt  = 1'b1;
                    else if (bus.if_req)  if_gnt  = 1'b1;
                    else                  dma_gnt = bus.dma_req;
                end
                default: begin
                    if (dma_aged)         dma_gnt = 1'b1;
                    else if (bus.ls_req)  ls_gnt  = 1'b1;
                    else if (bus.if_req)  if_gnt  = 1'b1;
                    else                  dma_gnt = bus.dma_req;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            ST_ARB: begin
                // The winning beat itself counts as the first beat of the burst.
                if (dma_gnt && bus.dma_lock) begin
                    state_d = ST_LOCK;
                    beat_d  = BW'(1);
                end
            end
            ST_LOCK: begin
                if (!bus.dma_lock) begin
                    state_d = ST_ARB;
                    beat_d  = '0;
                end else if (dma_gnt) begin
                    if ((beat_q + BW'(1)) == BURST_MAX) begin
                        state_d = ST_YIELD;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_ARB;
                beat_d  = '0;
            end
        endcase

        // Aging counter saturates so dma_aged stays asserted until DMA wins.
        if (!bus.dma_req || dma_gnt)  wait_d = '0;
        else if (wait_q != WAIT_MAX)  wait_d = wait_q + WW'(1);
        else                          wait_d = wait_q;

        // Remember who owns the read data arriving next cycle.
        tag_d = TAG_NONE;
        if (if_gnt)                         tag_d = TAG_IF;
        else if (ls_gnt && !bus.ls_we)      tag_d = TAG_LS;
        else if (dma_gnt && !bus.dma_we)    tag_d = TAG_DMA;
    end

    // ------------------------------------------------------------------
    // SRAM mux from the winner; all-zero when idle
    // ------------------------------------------------------------------
    always_comb begin
        bus.sram_en    = if_gnt | ls_gnt | dma_gnt;
        bus.sram_we    = 1'b0;
        bus.sram_be    = 4'h0;
        bus.sram_addr  = '0;
        bus.sram_wdata = 32'h0;
        if (ls_gnt) begin
            bus.sram_we    = bus.ls_we;
            bus.sram_be    = bus.ls_we ? bus.ls_be : 4'hF;
            bus.sram_addr  = bus.ls_addr[SRAM_AW+1:2];
            bus.sram_wdata = bus.ls_we ? bus.ls_wdata : 32'h0;
        end else if (if_gnt) begin
            bus.sram_be    = 4'hF;
            bus.sram_addr  = bus.if_addr[SRAM_AW+1:2];
        end else if (dma_gnt) begin
            bus.sram_we    = bus.dma_we;
            bus.sram_be    = 4'hF;
            bus.sram_addr  = bus.dma_addr[SRAM_AW+1:2];
            bus.sram_wdata = bus.dma_we ? bus.dma_wdata : 32'h0;
        end
    end

    assign bus.if_gnt  = if_gnt;
    assign bus.ls_gnt  = ls_gnt;
    assign bus.dma_gnt = dma_gnt;

    // A read in flight when reset arrives is dropped.
    assign bus.if_rvalid  = !rst_i && (tag_q == TAG_IF);
    assign bus.ls_rvalid  = !rst_i && (tag_q == TAG_LS);
    assign bus.dma_rvalid = !rst_i && (tag_q == TAG_DMA);
    assign bus.rdata      = (!rst_i && (tag_q != TAG_NONE)) ? bus.sram_rdata : 32'h0;

    // Byte offset and bits above the SRAM window are ignored (addresses alias).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:SRAM_AW+2],  bus.if_addr[1:0],
                                bus.ls_addr[31:SRAM_AW+2],  bus.ls_addr[1:0],
                                bus.dma_addr[31:SRAM_AW+2], bus.dma_addr[1:0]};

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_q, perf_ls_q, perf_dma_q, perf_conf_q;
    logic        conflict;

    assign conflict = (bus.if_req & bus.ls_req) | (bus.if_req & bus.dma_req) |
                      (bus.ls_req & bus.dma_req);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_if_q   <= 32'h0;
            perf_ls_q   <= 32'h0;
            perf_dma_q  <= 32'h0;
            perf_conf_q <= 32'h0;
        end else begin
            perf_if_q   <= perf_if_q   + {31'h0, if_gnt};
            perf_ls_q   <= perf_ls_q   + {31'h0, ls_gnt};
            perf_dma_q  <= perf_dma_q  + {31'h0, dma_gnt};
            perf_conf_q <= perf_conf_q + {31'h0, conflict};
        end
    end

    assign bus.perf_if_grants  = perf_if_q;
    assign bus.perf_ls_grants  = perf_ls_q;
    assign bus.perf_dma_grants = perf_dma_q;
    assign bus.perf_conflict   = perf_conf_q;
`endif
endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
    localparam int SRAM_AW   = 12;
    localparam int MAX_WAIT  = 8;
    localparam int MAX_BURST = 16;
    localparam int DEPTH     = 1 << SRAM_AW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_port_arbiter_if #(.SRAM_AW(SRAM_AW)) bus ();

    sram_port_arbiter #(
        .SRAM_AW(SRAM_AW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] init_word(int i);
        if (i == 256) return 32'h0000_000F;
        return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] be_mask(logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic int word_of(logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // SRAM array model: one-cycle read latency, byte-masked writes.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
        end else if (bus.sram_en) begin
            if (bus.sram_we)
                mem[bus.sram_addr] <= (mem[bus.sram_addr] & ~be_mask(bus.sram_be)) |
                                      (bus.sram_wdata & be_mask(bus.sram_be));
            else
                bus.sram_rdata <= mem[bus.sram_addr];
        end
    end

    // Reference model (abstract: who should win, burst bookkeeping, expected memory).
    bit          m_locked, m_yield;
    int          m_wait, m_beats, m_pend;   // m_pend: 0 none, 1 IF, 2 LS, 3 DMA
    logic [31:0] m_pend_data;
    logic [31:0] exp_mem [DEPTH];
    int          m_pif, m_pls, m_pdma, m_pconf;

    int          win;
    bit          e_we;
    int          e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;

    // Observed values captured at the sampling point of the last cycle.
    logic o_if, o_ls, o_dma, o_ls_rvalid, o_dma_rvalid, o_if_rvalid;
    logic [31:0] o_addr, o_be, o_rdata;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (rst)                                            return 0;
        if (m_locked)                                       return bus.dma_req ? 3 : 0;
        if (!m_yield && bus.dma_req && m_wait >= MAX_WAIT)  return 3;
        if (bus.ls_req)                                     return 2;
        if (bus.if_req)                                     return 1;
        if (bus.dma_req)                                    return 3;
        return 0;
    endfunction

    task automatic derive();
        e_we = 1'b0; e_addr = 0; e_be = 4'h0; e_wd = 32'h0;
        case (win)
            1: begin e_addr = word_of(bus.if_addr); e_be = 4'hF; end
            2: begin
                e_addr = word_of(bus.ls_addr); e_we = bus.ls_we;
                e_be = bus.ls_we ? bus.ls_be : 4'hF; e_wd = bus.ls_wdata;
            end
            3: begin
                e_addr = word_of(bus.dma_addr); e_we = bus.dma_we;
                e_be = 4'hF; e_wd = bus.dma_wdata;
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs();
        chk("if_gnt",  32'(bus.if_gnt),  32'(win == 1));
        chk("ls_gnt",  32'(bus.ls_gnt),  32'(win == 2));
        chk("dma_gnt", 32'(bus.dma_gnt), 32'(win == 3));
        chk("sram_en", 32'(bus.sram_en), 32'(win != 0));
        chk("sram_we", 32'(bus.sram_we), 32'(e_we));
        if (win != 0) begin
            chk("sram_addr", 32'(bus.sram_addr), 32'(e_addr));
            chk("sram_be",   32'(bus.sram_be),   32'(e_be));
            if (e_we) chk("sram_wdata", bus.sram_wdata, e_wd);
        end
        chk("if_rvalid",  32'(bus.if_rvalid),  32'(!rst && m_pend == 1));
        chk("ls_rvalid",  32'(bus.ls_rvalid),  32'(!rst && m_pend == 2));
        chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(!rst && m_pend == 3));
        if (!rst && m_pend != 0) chk("rdata", bus.rdata, m_pend_data);
        if (rst) begin
            chk("rst_sram_addr",  32'(bus.sram_addr), 32'h0);
            chk("rst_sram_be",    32'(bus.sram_be),   32'h0);
            chk("rst_sram_wdata", bus.sram_wdata,     32'h0);
            chk("rst_rdata",      bus.rdata,          32'h0);
        end
`ifdef ARB_PERF_CNT_EN
        chk("perf_if",   bus.perf_if_grants,  32'(m_pif));
        chk("perf_ls",   bus.perf_ls_grants,  32'(m_pls));
        chk("perf_dma",  bus.perf_dma_grants, 32'(m_pdma));
        chk("perf_conf", bus.perf_conflict,   32'(m_pconf));
`endif
    endtask

    task automatic model_update();
        int nreq;
        if (rst) begin
            m_locked = 0; m_yield = 0; m_wait = 0; m_beats = 0; m_pend = 0;
            m_pif = 0; m_pls = 0; m_pdma = 0; m_pconf = 0;
            for (int i = 0; i < DEPTH; i++) exp_mem[i] = init_word(i);
            return;
        end
        nreq = int'(bus.if_req) + int'(bus.ls_req) + int'(bus.dma_req);
        if (nreq >= 2) m_pconf++;
        if (win == 1) m_pif++;
        if (win == 2) m_pls++;
        if (win == 3) m_pdma++;
        m_pend = 0;
        if (win != 0) begin
            if (e_we) exp_mem[e_addr] = (exp_mem[e_addr] & ~be_mask(e_be)) | (e_wd & be_mask(e_be));
            else begin m_pend = win; m_pend_data = exp_mem[e_addr]; end
        end
        if (!bus.dma_req || win == 3) m_wait = 0;
        else if (m_wait < MAX_WAIT)   m_wait++;
        if (m_locked) begin
            if (!bus.dma_lock) m_locked = 0;
            else if (win == 3) begin
                m_beats++;
                if (m_beats == MAX_BURST) begin m_locked = 0; m_yield = 1; end
            end
        end else if (m_yield) begin
            m_yield = 0;
        end else if (win == 3 && bus.dma_lock) begin
            m_locked = 1; m_beats = 1;
        end
    endtask

    // One clock: inputs already applied at posedge+1; sample at negedge.
    task automatic cycle();
        @(negedge clk);
        win = pick();
        derive();
        o_if = bus.if_gnt; o_ls = bus.ls_gnt; o_dma = bus.dma_gnt;
        o_if_rvalid = bus.if_rvalid; o_ls_rvalid = bus.ls_rvalid; o_dma_rvalid = bus.dma_rvalid;
        o_addr = 32'(bus.sram_addr); o_be = 32'(bus.sram_be); o_rdata = bus.rdata;
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req = 0; bus.ls_req = 0; bus.dma_req = 0;
        bus.ls_we = 0; bus.dma_we = 0; bus.dma_lock = 0;
    endtask

    initial begin
        int denied, run;
        bit seen, p_if, p_ls, p_dma;

        rst = 1'b1;
        idle_inputs();
        bus.if_addr = 0; bus.ls_addr = 0; bus.dma_addr = 0;
        bus.ls_wdata = 0; bus.dma_wdata = 0; bus.ls_be = 0;
        @(posedge clk); #1;
        cycle();
        cycle();
        // Requests present during reset must not be granted.
        bus.if_req = 1; bus.ls_req = 1; bus.dma_req = 1;
        cycle();
        chk("rst_no_gnt", 32'({o_if, o_ls, o_dma}), 32'h0);
        idle_inputs();
        rst = 1'b0;
        cycle();

        // LS read of 0x400 -> word 0x100 holding 0xF.
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h0000_0400;
        cycle();
        chk("t1_ls_gnt", 32'(o_ls), 32'h1);
        chk("t1_addr", o_addr, 32'h100);
        bus.ls_req = 0;
        cycle();
        chk("t1_ls_rvalid", 32'(o_ls_rvalid), 32'h1);
        chk("t1_rdata", o_rdata, 32'h0000_000F);
        chk("t1_other_rvalid", 32'({o_if_rvalid, o_dma_rvalid}), 32'h0);

        // LS byte write to 0x404.
        bus.ls_req = 1; bus.ls_we = 1; bus.ls_be = 4'b0010;
        bus.ls_wdata = 32'hAABB_CCDD; bus.ls_addr = 32'h0000_0404;
        cycle();
        chk("t5_be", o_be, 32'h2);
        chk("t5_addr", o_addr, 32'h101);
        idle_inputs();
        cycle();
        chk("t5_no_rvalid", 32'(o_ls_rvalid), 32'h0);

        // IF and LS together: LS wins, IF gets the first free cycle.
        bus.if_req = 1; bus.if_addr = 32'h0000_0010;
        bus.ls_req = 1; bus.ls_we = 0; bus.ls_addr = 32'h0000_0020;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t2_ls_wins", 32'({o_ls, o_if}), 32'h2);
        end
        bus.ls_req = 0;
        cycle();
        chk("t2_if_after", 32'(o_if), 32'h1);
        idle_inputs();
        cycle();

        // DMA aging against a continuous LS stream, twice (counter restarts).
        bus.ls_req = 1; bus.ls_addr = 32'h0000_0100;
        bus.dma_req = 1; bus.dma_lock = 0; bus.dma_addr = 32'h0000_0200;
        for (int rep = 0; rep < 2; rep++) begin
            denied = 0;
            for (int i = 0; i < 20; i++) begin
                cycle();
                if (o_dma) break;
                denied++;
            end
            chk("t3_aging_denied", 32'(denied), 32'(MAX_WAIT));
        end
        idle_inputs();
        cycle();

        // Locked burst: aging win, 16 beats, YIELD goes to LS.
        bus.ls_req = 1; bus.dma_req = 1; bus.dma_lock = 1;
        run = 0; seen = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            if (o_dma) run++;
            else begin
                if (run > 0 && !seen) begin
                    chk("t4_burst_len", 32'(run), 32'(MAX_BURST));
                    chk("t4_yield_ls", 32'(o_ls), 32'h1);
                    seen = 1;
                end
                run = 0;
            end
        end
        chk("t4_burst_seen", 32'(seen), 32'h1);
        idle_inputs();
        cycle();

        // Reset in the cycle after a DMA read grant inside LOCK.
        bus.dma_req = 1; bus.dma_lock = 1; bus.dma_we = 0; bus.dma_addr = 32'h0000_0300;
        cycle();
        cycle();
        chk("t6_lock_gnt", 32'(o_dma), 32'h1);
        rst = 1;
        cycle();
        chk("t6_rst_rvalid", 32'(o_dma_rvalid), 32'h0);
        rst = 0;
        bus.ls_req = 1; bus.ls_addr = 32'h0000_0040;
        cycle();
        chk("t6_post_rst_ls", 32'({o_ls, o_dma}), 32'h2);
        idle_inputs();
        cycle();

        // Randomized traffic; requests stay stable until granted.
        p_if = 0; p_ls = 0; p_dma = 0;
        for (int n = 0; n < 2000; n++) begin
            if (!p_if && $urandom_range(0, 2) == 0) begin
                p_if = 1;
                bus.if_addr = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            end
            if (!p_ls && $urandom_range(0, 2) == 0) begin
                p_ls = 1;
                bus.ls_we = 1'($urandom_range(0, 1));
                bus.ls_be = 4'($urandom);
                bus.ls_wdata = $urandom;
                bus.ls_addr = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 63)) << 2);
            end
            if (!p_dma && $urandom_range(0, 1) == 0) begin
                p_dma = 1;
                bus.dma_we = 1'($urandom_range(0, 1));
                bus.dma_lock = ($urandom_range(0, 3) != 0);
                bus.dma_wdata = $urandom;
                bus.dma_addr = (32'($urandom_range(0, 63)) << 2);
            end
            bus.if_req = p_if; bus.ls_req = p_ls; bus.dma_req = p_dma;
            rst = ($urandom_range(0, 299) == 0);
            cycle();
            if (win == 1) p_if = 0;
            if (win == 2) p_ls = 0;
            if (win == 3) p_dma = 0;
        end
        rst = 0;
        idle_inputs();
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
